// File: rtl/scroll_ctrl.sv
// Sequencing controller for the 13-digit scrolling ID display: decides when the
// circular shifter loads, shifts and in which direction, with run/pause, step and dwell.
module scroll_ctrl #(
  parameter int DIGITS      = 13,
  parameter int TICK_BASE   = 50,
  parameter int DWELL_STEPS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      run_toggle,
  input  logic                      step,
  input  logic                      dir,
  input  logic [1:0]                speed,
  output logic                      ld,
  output logic                      shift_en,
  output logic                      shift_dir,
  output logic [$clog2(DIGITS)-1:0] pos,
  output logic                      running,
  output logic                      wrap
);

  localparam int PW = $clog2(DIGITS);
  localparam int NW = $clog2(TICK_BASE * 8 + 1);
  localparam int DW = (DWELL_STEPS > 0) ? $clog2(DWELL_STEPS + 1) : 1;
  localparam logic [PW-1:0] POS_MAX    = PW'(DIGITS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_STEPS > 0) ? DWELL_STEPS - 1 : 0);

  typedef enum logic [1:0] {LOAD, RUN, DWELL, PAUSE} state_t;

  state_t        state;
  logic [NW-1:0] presc;
  logic [NW-1:0] per_last;
  logic [DW-1:0] dwell_cnt;
  logic          period_done;
  logic [PW-1:0] pos_next;

  // Period length is TICK_BASE << (3-speed); compare against N-1 so that a
  // speed increase mid-count completes the period on the very next tick.
  always_comb begin
    per_last = NW'(TICK_BASE - 1);
    case (speed)
      2'd0:    per_last = NW'(TICK_BASE * 8 - 1);
      2'd1:    per_last = NW'(TICK_BASE * 4 - 1);
      2'd2:    per_last = NW'(TICK_BASE * 2 - 1);
      default: per_last = NW'(TICK_BASE - 1);
    endcase
    period_done = tick && (presc >= per_last);
    if (dir) pos_next = (pos == '0) ? POS_MAX : pos - PW'(1);
    else     pos_next = (pos == POS_MAX) ? '0 : pos + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      presc     <= '0;
      dwell_cnt <= '0;
      pos       <= '0;
      ld        <= 1'b0;
      shift_en  <= 1'b0;
      shift_dir <= 1'b0;
      running   <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      ld       <= 1'b0;
      shift_en <= 1'b0;
      wrap     <= 1'b0;
      case (state)
        LOAD: begin
          ld      <= 1'b1;
          running <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (run_toggle) begin
            state     <= PAUSE;
            presc     <= '0;
            dwell_cnt <= '0;
            running   <= 1'b0;
          end else if (period_done) begin
            presc     <= '0;
            shift_en  <= 1'b1;
            shift_dir <= dir;
            pos       <= pos_next;
            if (pos_next == '0) begin
              wrap <= 1'b1;
              if (DWELL_STEPS > 0) begin
                state     <= DWELL;
                dwell_cnt <= '0;
              end
            end
          end else if (tick) begin
            presc <= presc + NW'(1);
          end
        end
        DWELL: begin
          if (run_toggle) begin
            state     <= PAUSE;
            presc     <= '0;
            dwell_cnt <= '0;
            running   <= 1'b0;
          end else if (period_done) begin
            presc <= '0;
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              state     <= RUN;
            end else begin
              dwell_cnt <= dwell_cnt + DW'(1);
            end
          end else if (tick) begin
            presc <= presc + NW'(1);
          end
        end
        PAUSE: begin
          // run_toggle takes priority; a coincident step is dropped.
          if (run_toggle) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end else if (step) begin
            shift_en  <= 1'b1;
            shift_dir <= dir;
            pos       <= pos_next;
            if (pos_next == '0) wrap <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl: one instance without dwell, one with a 4-step dwell,
// both at TICK_BASE=2 and sharing stimulus.
module tb_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       run_toggle = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] speed = 2'd3;

  logic       ld0, se0, sd0, run0, wrap0;
  logic [3:0] pos0;
  logic       ld1, se1, sd1, run1, wrap1;
  logic [3:0] pos1;

  int vectors = 0;
  int errors  = 0;
  int se_cnt0 = 0;

  // values captured on the cycle right after a tick edge
  logic       c_se0, c_sd0, c_wrap0, c_run0;
  logic [3:0] c_pos0;
  logic       c_se1, c_wrap1, c_run1;
  logic [3:0] c_pos1;

  scroll_ctrl #(.DIGITS(13), .TICK_BASE(2), .DWELL_STEPS(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .run_toggle(run_toggle), .step(step),
    .dir(dir), .speed(speed), .ld(ld0), .shift_en(se0), .shift_dir(sd0),
    .pos(pos0), .running(run0), .wrap(wrap0));

  scroll_ctrl #(.DIGITS(13), .TICK_BASE(2), .DWELL_STEPS(4)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .run_toggle(run_toggle), .step(step),
    .dir(dir), .speed(speed), .ld(ld1), .shift_en(se1), .shift_dir(sd1),
    .pos(pos1), .running(run1), .wrap(wrap1));

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (se0) se_cnt0++;
      vectors++;
      if ((ld0 & se0) !== 1'b0 || (ld1 & se1) !== 1'b0) begin
        errors++;
        $display("FAIL ld_shift_overlap: ld0=%b se0=%b ld1=%b se1=%b expected no overlap", ld0, se0, ld1, se1);
      end
    end
  end

  // driver tasks
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick4();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    c_se0 = se0; c_sd0 = sd0; c_wrap0 = wrap0; c_run0 = run0; c_pos0 = pos0;
    c_se1 = se1; c_wrap1 = wrap1; c_run1 = run1; c_pos1 = pos1;
    repeat (3) clk1();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) clk1();
    reset = 1'b1;
    clk1();
    clk1();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) clk1();
    vectors++;
    if ({ld0, se0, sd0, run0, wrap0, pos0} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: ld=%b se=%b sd=%b run=%b wrap=%b pos=%0d expected all 0", ld0, se0, sd0, run0, wrap0, pos0);
    end
    reset = 1'b1;
    clk1();
    vectors++;
    if (ld0 !== 1'b1 || ld1 !== 1'b1) begin
      errors++;
      $display("FAIL load_pulse: ld0=%b ld1=%b expected 1", ld0, ld1);
    end
    vectors++;
    if (pos0 !== 4'd0 || se0 !== 1'b0) begin
      errors++;
      $display("FAIL load_pos: pos=%0d se=%b expected pos=0 se=0", pos0, se0);
    end
    clk1();
    vectors++;
    if (ld0 !== 1'b0 || run0 !== 1'b1 || se0 !== 1'b0) begin
      errors++;
      $display("FAIL after_load: ld=%b run=%b se=%b expected ld=0 run=1 se=0", ld0, run0, se0);
    end
    repeat (4) clk1();
    vectors++;
    if (ld0 !== 1'b0 || se0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_run: ld=%b se=%b expected 0 0", ld0, se0);
    end
  endtask

  task automatic test_timing_fast();
    logic       exp_se;
    logic [3:0] exp_pos;
    do_reset();
    speed = 2'd3; dir = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      tick4();
      exp_se = (i % 2 == 0);
      vectors++;
      if (c_se0 !== exp_se) begin
        errors++;
        $display("FAIL fast_shift_en tick %0d: got %b expected %b", i, c_se0, exp_se);
      end
      if (exp_se) begin
        exp_pos = 4'((i / 2) % 13);
        vectors++;
        if (c_pos0 !== exp_pos || c_sd0 !== 1'b0) begin
          errors++;
          $display("FAIL fast_pos tick %0d: pos=%0d sd=%b expected pos=%0d sd=0", i, c_pos0, c_sd0, exp_pos);
        end
        vectors++;
        if (c_wrap0 !== (exp_pos == 4'd0)) begin
          errors++;
          $display("FAIL fast_wrap tick %0d: got %b expected %b", i, c_wrap0, exp_pos == 4'd0);
        end
      end
    end
  endtask

  task automatic test_timing_slow();
    logic exp_se;
    do_reset();
    speed = 2'd0; dir = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick4();
      exp_se = (i % 16 == 0);
      vectors++;
      if (c_se0 !== exp_se) begin
        errors++;
        $display("FAIL slow_shift_en tick %0d: got %b expected %b", i, c_se0, exp_se);
      end
    end
    vectors++;
    if (c_pos0 !== 4'd2) begin
      errors++;
      $display("FAIL slow_pos: got %0d expected 2", c_pos0);
    end
    speed = 2'd3;
  endtask

  task automatic test_direction();
    do_reset();
    speed = 2'd3; dir = 1'b1;
    repeat (2) tick4();
    vectors++;
    if (c_se0 !== 1'b1 || c_pos0 !== 4'd12 || c_sd0 !== 1'b1 || c_wrap0 !== 1'b0) begin
      errors++;
      $display("FAIL dir_right_from0: se=%b pos=%0d sd=%b wrap=%b expected 1 12 1 0", c_se0, c_pos0, c_sd0, c_wrap0);
    end
    do_reset();
    dir = 1'b0;
    repeat (2) tick4();
    dir = 1'b1;
    repeat (2) tick4();
    vectors++;
    if (c_se0 !== 1'b1 || c_pos0 !== 4'd0 || c_sd0 !== 1'b1 || c_wrap0 !== 1'b1) begin
      errors++;
      $display("FAIL dir_right_from1: se=%b pos=%0d sd=%b wrap=%b expected 1 0 1 1", c_se0, c_pos0, c_sd0, c_wrap0);
    end
    dir = 1'b0;
  endtask

  task automatic test_dwell();
    do_reset();
    speed = 2'd3; dir = 1'b0;
    repeat (26) tick4();
    vectors++;
    if (c_se1 !== 1'b1 || c_wrap1 !== 1'b1 || c_pos1 !== 4'd0) begin
      errors++;
      $display("FAIL dwell_wrap: se=%b wrap=%b pos=%0d expected 1 1 0", c_se1, c_wrap1, c_pos1);
    end
    for (int i = 1; i <= 10; i++) begin
      tick4();
      vectors++;
      if (c_se1 !== (i == 10) || c_run1 !== 1'b1) begin
        errors++;
        $display("FAIL dwell_tick %0d: se=%b run=%b expected se=%b run=1", i, c_se1, c_run1, i == 10);
      end
    end
    vectors++;
    if (c_pos1 !== 4'd1) begin
      errors++;
      $display("FAIL dwell_resume_pos: got %0d expected 1", c_pos1);
    end
  endtask

  task automatic test_pause_step();
    int base;
    do_reset();
    speed = 2'd3; dir = 1'b0;
    run_toggle = 1'b1;
    clk1();
    run_toggle = 1'b0;
    vectors++;
    if (run0 !== 1'b0 || se0 !== 1'b0) begin
      errors++;
      $display("FAIL pause_enter: run=%b se=%b expected 0 0", run0, se0);
    end
    base = se_cnt0;
    repeat (40) tick4();
    vectors++;
    if (se_cnt0 !== base || pos0 !== 4'd0) begin
      errors++;
      $display("FAIL pause_hold: shifts=%0d pos=%0d expected 0 shifts pos=0", se_cnt0 - base, pos0);
    end
    for (int i = 1; i <= 3; i++) begin
      step = 1'b1;
      clk1();
      step = 1'b0;
      vectors++;
      if (se0 !== 1'b1 || pos0 !== 4'(i) || run0 !== 1'b0) begin
        errors++;
        $display("FAIL step %0d: se=%b pos=%0d run=%b expected 1 %0d 0", i, se0, pos0, run0, i);
      end
      clk1();
    end
    vectors++;
    if (se_cnt0 - base !== 3) begin
      errors++;
      $display("FAIL step_count: got %0d expected 3", se_cnt0 - base);
    end
    run_toggle = 1'b1; step = 1'b1;
    clk1();
    run_toggle = 1'b0; step = 1'b0;
    vectors++;
    if (se0 !== 1'b0 || run0 !== 1'b1 || pos0 !== 4'd3) begin
      errors++;
      $display("FAIL toggle_step: se=%b run=%b pos=%0d expected 0 1 3", se0, run0, pos0);
    end
    tick4();
    tick = 1'b1; run_toggle = 1'b1;
    clk1();
    tick = 1'b0; run_toggle = 1'b0;
    vectors++;
    if (se0 !== 1'b0 || run0 !== 1'b0 || pos0 !== 4'd3) begin
      errors++;
      $display("FAIL toggle_on_tick: se=%b run=%b pos=%0d expected 0 0 3", se0, run0, pos0);
    end
    repeat (3) clk1();
    vectors++;
    if (se_cnt0 - base !== 3) begin
      errors++;
      $display("FAIL pause_total: got %0d expected 3", se_cnt0 - base);
    end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    speed = 2'd3; dir = 1'b0;
    repeat (29) tick4();
    reset = 1'b0;
    clk1();
    vectors++;
    if ({ld1, se1, sd1, run1, wrap1, pos1} !== 9'd0) begin
      errors++;
      $display("FAIL mid_dwell_reset: ld=%b se=%b sd=%b run=%b wrap=%b pos=%0d expected all 0", ld1, se1, sd1, run1, wrap1, pos1);
    end
    clk1();
    reset = 1'b1;
    clk1();
    vectors++;
    if (ld1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_dwell_reload: ld=%b expected 1", ld1);
    end
    clk1();
    vectors++;
    if (ld1 !== 1'b0 || run1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_dwell_ld_single: ld=%b run=%b expected 0 1", ld1, run1);
    end
    tick4();
    vectors++;
    if (c_se1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_dwell_first_tick: se=%b expected 0", c_se1);
    end
    tick4();
    vectors++;
    if (c_se1 !== 1'b1 || c_pos1 !== 4'd1) begin
      errors++;
      $display("FAIL mid_dwell_first_shift: se=%b pos=%0d expected 1 1", c_se1, c_pos1);
    end
  endtask

  initial begin
    test_reset();
    test_timing_fast();
    test_timing_slow();
    test_direction();
    test_dwell();
    test_pause_step();
    test_reset_mid_dwell();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
